mem_arbiter_2port: RTL and testbench

//  Shares one mem_system_hier instance (cache + four-bank memory) between a read-only

---
 rtl/mem_arbiter_2port.sv | 189 ++++++++++++++++++
 tb/tb_mem_arbiter_2port.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_2port.sv
// ============================================================================
// Module   : mem_arbiter_2port
// Purpose  : Shares one cache + four-bank memory system between a read-only
//            instruction-fetch port (I) and a read/write data port (D).
//            Requests are serialised. Done/DataOut/CacheHit are routed back to
//            the owning port. The losing port is held off through its stall.
//            A winning request is issued in the same cycle it is seen.
//            Hung grants are force-completed, and d_rd+d_wr is flagged.
// Config   : `define ARB_RR_EN -> round-robin on ties (port != last owner).
//            Otherwise D wins every tie.
// Ports    : clk, rst (sync, active-low)
//            I port : i_addr, i_rd -> i_data_out, i_done, i_stall, i_hit
//            D port : d_addr, d_data_in, d_rd, d_wr ->
//                     d_data_out, d_done, d_stall, d_hit
//            Memory : m_addr, m_data_in, m_rd, m_wr <- m_data_out, m_done,
//                     m_stall, m_hit
//            Errors : err_rdwr, err_timeout (sticky until reset)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter_2port #(
  parameter int TIMEOUT = 31,  // grant cycles without m_done before forced release
  parameter int CNT_W   = 6    // 2**CNT_W must exceed TIMEOUT
) (
  input  logic        clk,
  input  logic        rst,
  // instruction-fetch port
  input  logic [15:0] i_addr,
  input  logic        i_rd,
  output logic [15:0] i_data_out,
  output logic        i_done,
  output logic        i_stall,
  output logic        i_hit,
  // data port
  input  logic [15:0] d_addr,
  input  logic [15:0] d_data_in,
  input  logic        d_rd,
  input  logic        d_wr,
  output logic [15:0] d_data_out,
  output logic        d_done,
  output logic        d_stall,
  output logic        d_hit,
  // memory system side
  output logic [15:0] m_addr,
  output logic [15:0] m_data_in,
  output logic        m_rd,
  output logic        m_wr,
  input  logic [15:0] m_data_out,
  input  logic        m_done,
  input  logic        m_stall,
  input  logic        m_hit,
  // sticky error flags
  output logic        err_rdwr,
  output logic        err_timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_t;

  // The counter holds k-1 during the k-th cycle spent in a grant state, so the
  // forced release lands on grant cycle TIMEOUT.
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_last_d;       // 1: last completed transaction belonged to D
  logic             r_err_rdwr;
  logic             r_err_timeout;

  logic w_i_req;
  logic w_d_req;
  logic w_tie_to_i;
  logic w_d_wins;
  logic w_issue;
  logic w_own_i;
  logic w_own_d;
  logic w_tmo;
  logic w_fin;

  assign w_i_req = i_rd;
  assign w_d_req = d_rd | d_wr;

  // On a tie, I is preferred only when D owned the bus last (round-robin).
  // The owner history is tracked in both builds, so only this select differs.
`ifdef ARB_RR_EN
  assign w_tie_to_i = r_last_d;
`else
  assign w_tie_to_i = 1'b0 & r_last_d;
`endif

  // D takes the bus whenever it requests, unless there is a tie that is
  // resolved in I's favour.
  assign w_d_wins = w_d_req & ~(w_i_req & w_tie_to_i);
  assign w_issue  = (r_state == IDLE) & (w_i_req | w_d_req) & ~m_stall;

  // The owner is either the granted port or the port being issued right now.
  // Issue-cycle ownership gives the zero-latency path.
  assign w_own_i  = (r_state == GNT_I) | (w_issue & ~w_d_wins);
  assign w_own_d  = (r_state == GNT_D) | (w_issue &  w_d_wins);

  // A real m_done takes precedence over a timeout in the same cycle.
  assign w_tmo    = (r_state != IDLE) & (r_cnt == C_CNT_LAST) & ~m_done;
  assign w_fin    = m_done | w_tmo;

  always_comb begin
    m_addr     = 16'h0000;
    m_data_in  = 16'h0000;
    m_rd       = 1'b0;
    m_wr       = 1'b0;
    i_data_out = 16'h0000;
    i_done     = 1'b0;
    i_hit      = 1'b0;
    d_data_out = 16'h0000;
    d_done     = 1'b0;
    d_hit      = 1'b0;

    if (w_own_i) begin
      m_addr     = i_addr;
      m_rd       = i_rd;
      i_done     = w_fin;
      i_data_out = m_done ? m_data_out : 16'h0000;
      i_hit      = m_done & m_hit;
    end else if (w_own_d) begin
      // A simultaneous read+write is issued as a write.
      m_addr     = d_addr;
      m_data_in  = d_data_in;
      m_wr       = d_wr;
      m_rd       = d_rd & ~d_wr;
      d_done     = w_fin;
      d_data_out = m_done ? m_data_out : 16'h0000;
      d_hit      = m_done & m_hit;
    end

    // The owner sees only m_stall. The other port is also held off while the
    // bus is granted away, or while it loses arbitration in IDLE.
    i_stall = m_stall | (r_state == GNT_D) | ((r_state == IDLE) & w_d_wins);
    d_stall = m_stall | (r_state == GNT_I) | ((r_state == IDLE) & w_i_req & ~w_d_wins);
  end

  assign err_rdwr    = r_err_rdwr;
  assign err_timeout = r_err_timeout;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_last_d      <= 1'b0;
      r_err_rdwr    <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      if (d_rd & d_wr) begin
        r_err_rdwr <= 1'b1;
      end

      case (r_state)
        IDLE: begin
          if (w_issue) begin
            r_cnt <= '0;
            if (m_done) begin
              // Completed in the issue cycle, so there is no grant state.
              r_last_d <= w_d_wins;
            end else begin
              r_state <= w_d_wins ? GNT_D : GNT_I;
            end
          end
        end
        GNT_I, GNT_D: begin
          if (w_fin) begin
            r_state  <= IDLE;
            r_last_d <= (r_state == GNT_D);
            if (w_tmo) begin
              r_err_timeout <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter_2port.sv
// ============================================================================
// Module   : tb_mem_arbiter_2port
// Purpose  : Self-checking bench for mem_arbiter_2port.
//            The memory system is a stub driven directly from the bench.
//            A vector table covers cycle-by-cycle behaviour: reset, D write then
//            read, tie arbitration, m_stall handling, read+write, and reset
//            mid-miss.
//            Hand-written sequences cover the grant timeout and repeated ties.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter_2port;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] i_addr;
  logic        i_rd;
  logic [15:0] i_data_out;
  logic        i_done, i_stall, i_hit;
  logic [15:0] d_addr, d_data_in;
  logic        d_rd, d_wr;
  logic [15:0] d_data_out;
  logic        d_done, d_stall, d_hit;
  logic [15:0] m_addr, m_data_in;
  logic        m_rd, m_wr;
  logic [15:0] m_data_out;
  logic        m_done, m_stall, m_hit;
  logic        err_rdwr, err_timeout;

  always #5 clk = ~clk;

  mem_arbiter_2port #(.TIMEOUT(31), .CNT_W(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_addr     (i_addr),
    .i_rd       (i_rd),
    .i_data_out (i_data_out),
    .i_done     (i_done),
    .i_stall    (i_stall),
    .i_hit      (i_hit),
    .d_addr     (d_addr),
    .d_data_in  (d_data_in),
    .d_rd       (d_rd),
    .d_wr       (d_wr),
    .d_data_out (d_data_out),
    .d_done     (d_done),
    .d_stall    (d_stall),
    .d_hit      (d_hit),
    .m_addr     (m_addr),
    .m_data_in  (m_data_in),
    .m_rd       (m_rd),
    .m_wr       (m_wr),
    .m_data_out (m_data_out),
    .m_done     (m_done),
    .m_stall    (m_stall),
    .m_hit      (m_hit),
    .err_rdwr   (err_rdwr),
    .err_timeout(err_timeout)
  );

  // One record per clock cycle. Inputs are driven just after posedge, and the
  // expected outputs are compared at the following negedge.
  // Group encodings: mrw={m_rd,m_wr}, i/d={done,stall,hit},
  // err={err_rdwr,err_timeout}.
  typedef struct {
    bit          chk;
    string       name;
    logic        rst;
    logic [15:0] ia;
    logic        ird;
    logic [15:0] da;
    logic [15:0] dd;
    logic        drd;
    logic        dwr;
    logic [15:0] mdo;
    logic        mdone;
    logic        mstall;
    logic        mhit;
    logic [15:0] e_ma;
    logic [15:0] e_mdi;
    logic [1:0]  e_mrw;
    logic [2:0]  e_i;
    logic [15:0] e_ido;
    logic [2:0]  e_d;
    logic [15:0] e_ddo;
    logic [1:0]  e_err;
  } vec_t;

  vec_t vq[$];
  int   errors = 0;
  int   checks = 0;

  task automatic add(input bit chk, input string nm, input logic r,
                     input logic [15:0] ia, input logic ird,
                     input logic [15:0] da, input logic [15:0] dd,
                     input logic drd, input logic dwr,
                     input logic [15:0] mdo, input logic mdone,
                     input logic mstall, input logic mhit,
                     input logic [15:0] e_ma, input logic [15:0] e_mdi,
                     input logic [1:0] e_mrw, input logic [2:0] e_i,
                     input logic [15:0] e_ido, input logic [2:0] e_d,
                     input logic [15:0] e_ddo, input logic [1:0] e_err);
    vec_t t;
    t.chk = chk; t.name = nm; t.rst = r;
    t.ia = ia; t.ird = ird; t.da = da; t.dd = dd; t.drd = drd; t.dwr = dwr;
    t.mdo = mdo; t.mdone = mdone; t.mstall = mstall; t.mhit = mhit;
    t.e_ma = e_ma; t.e_mdi = e_mdi; t.e_mrw = e_mrw; t.e_i = e_i;
    t.e_ido = e_ido; t.e_d = e_d; t.e_ddo = e_ddo; t.e_err = e_err;
    vq.push_back(t);
  endtask

  task automatic apply(input vec_t t);
    rst        = t.rst;
    i_addr     = t.ia;
    i_rd       = t.ird;
    d_addr     = t.da;
    d_data_in  = t.dd;
    d_rd       = t.drd;
    d_wr       = t.dwr;
    m_data_out = t.mdo;
    m_done     = t.mdone;
    m_stall    = t.mstall;
    m_hit      = t.mhit;
  endtask

  task automatic check_vec(input vec_t t);
    logic [72:0] got, exp;
    got = {m_addr, m_data_in, m_rd, m_wr, i_done, i_stall, i_hit, i_data_out,
           d_done, d_stall, d_hit, d_data_out, err_rdwr, err_timeout};
    exp = {t.e_ma, t.e_mdi, t.e_mrw, t.e_i, t.e_ido, t.e_d, t.e_ddo, t.e_err};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got ma=%h mdi=%h mrw=%b i=%b ido=%h d=%b ddo=%h err=%b | exp ma=%h mdi=%h mrw=%b i=%b ido=%h d=%b ddo=%h err=%b",
               t.name, m_addr, m_data_in, {m_rd, m_wr}, {i_done, i_stall, i_hit},
               i_data_out, {d_done, d_stall, d_hit}, d_data_out,
               {err_rdwr, err_timeout}, t.e_ma, t.e_mdi, t.e_mrw, t.e_i,
               t.e_ido, t.e_d, t.e_ddo, t.e_err);
    end
  endtask

  initial begin
    int  n;
    bit  seen;
    bit  exp_d;

    rst = 1'b0; i_addr = '0; i_rd = 1'b0; d_addr = '0; d_data_in = '0;
    d_rd = 1'b0; d_wr = 1'b0; m_data_out = '0; m_done = 1'b0;
    m_stall = 1'b0; m_hit = 1'b0;

    //   chk name              rst ia       ird da       dd       drd dwr mdo      mdn mst mht | e_ma     e_mdi    mrw    i       ido      d       ddo      err
    add(0, "rst",             0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 2'b00, 3'b000, 16'h0000, 3'b000, 16'h0000, 2'b00);
    add(1, "reset_idle",      1, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 2'b00, 3'b000, 16'h0000, 3'b000, 16'h0000, 2'b00);
    // D write 0x6002=0xBEEF with a two-cycle miss, then a read that hits
    add(1, "dwr_issue",       1, 16'h0000, 0, 16'h6002, 16'hBEEF, 0, 1, 16'h0000, 0, 0, 0, 16'h6002, 16'hBEEF, 2'b01, 3'b010, 16'h0000, 3'b000, 16'h0000, 2'b00);
    add(1, "dwr_wait",        1, 16'h0000, 0, 16'h6002, 16'hBEEF, 0, 1, 16'h0000, 0, 0, 0, 16'h6002, 16'hBEEF, 2'b01, 3'b010, 16'h0000, 3'b000, 16'h0000, 2'b00);
    add(1, "dwr_done",        1, 16'h0000, 0, 16'h6002, 16'hBEEF, 0, 1, 16'h0000, 1, 0, 0, 16'h6002, 16'hBEEF, 2'b01, 3'b010, 16'h0000, 3'b100, 16'h0000, 2'b00);
    add(1, "drd_hit",         1, 16'h0000, 0, 16'h6002, 16'h0000, 1, 0, 16'hBEEF, 1, 0, 1, 16'h6002, 16'h0000, 2'b10, 3'b010, 16'h0000, 3'b101, 16'hBEEF, 2'b00);
    add(1, "idle_after_rd",   1, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 2'b00, 3'b000, 16'h0000, 3'b000, 16'h0000, 2'b00);
    add(0, "rst2",            0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 2'b00, 3'b000, 16'h0000, 3'b000, 16'h0000, 2'b00);
    // simultaneous requests: D first, I issued the cycle after d_done
    add(1, "tie_issue",       1, 16'h0100, 1, 16'h0200, 16'h0000, 1, 0, 16'h0000, 0, 0, 0, 16'h0200, 16'h0000, 2'b10, 3'b010, 16'h0000, 3'b000, 16'h0000, 2'b00);
    add(1, "tie_gnt_d",       1, 16'h0100, 1, 16'h0200, 16'h0000, 1, 0, 16'h0000, 0, 0, 0, 16'h0200, 16'h0000, 2'b10, 3'b010, 16'h0000, 3'b000, 16'h0000, 2'b00);
    add(1, "tie_d_done",      1, 16'h0100, 1, 16'h0200, 16'h0000, 1, 0, 16'h5555, 1, 0, 0, 16'h0200, 16'h0000, 2'b10, 3'b010, 16'h0000, 3'b100, 16'h5555, 2'b00);
    add(1, "i_issue",         1, 16'h0100, 1, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 16'h0100, 16'h0000, 2'b10, 3'b000, 16'h0000, 3'b010, 16'h0000, 2'b00);
    add(1, "i_done_hit",      1, 16'h0100, 1, 16'h0000, 16'h0000, 0, 0, 16'hA5A5, 1, 0, 1, 16'h0100, 16'h0000, 2'b10, 3'b101, 16'hA5A5, 3'b010, 16'h0000, 2'b00);
    add(1, "idle_after_i",    1, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 2'b00, 3'b000, 16'h0000, 3'b000, 16'h0000, 2'b00);
    // memory busy in IDLE blocks issue, and stalls the owner during a grant
    add(1, "mstall_idle",     1, 16'h0000, 0, 16'h0300, 16'h0000, 1, 0, 16'h0000, 0, 1, 0, 16'h0000, 16'h0000, 2'b00, 3'b010, 16'h0000, 3'b010, 16'h0000, 2'b00);
    add(1, "mstall_release",  1, 16'h0000, 0, 16'h0300, 16'h0000, 1, 0, 16'h0000, 0, 0, 0, 16'h0300, 16'h0000, 2'b10, 3'b010, 16'h0000, 3'b000, 16'h0000, 2'b00);
    add(1, "owner_stall",     1, 16'h0000, 0, 16'h0300, 16'h0000, 1, 0, 16'h0000, 0, 1, 0, 16'h0300, 16'h0000, 2'b10, 3'b010, 16'h0000, 3'b010, 16'h0000, 2'b00);
    add(1, "owner_done",      1, 16'h0000, 0, 16'h0300, 16'h0000, 1, 0, 16'h0F0F, 1, 0, 0, 16'h0300, 16'h0000, 2'b10, 3'b010, 16'h0000, 3'b100, 16'h0F0F, 2'b00);
    // read+write together goes out as a write; the error flag is sticky
    add(1, "rdwr_write",      1, 16'h0000, 0, 16'h6004, 16'h1234, 1, 1, 16'h0000, 1, 0, 0, 16'h6004, 16'h1234, 2'b01, 3'b010, 16'h0000, 3'b100, 16'h0000, 2'b00);
    add(1, "rdwr_sticky",     1, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 2'b00, 3'b000, 16'h0000, 3'b000, 16'h0000, 2'b10);
    add(1, "rdwr_sticky2",    1, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 2'b00, 3'b000, 16'h0000, 3'b000, 16'h0000, 2'b10);
    // reset during a D miss: no d_done, errors cleared, I served normally
    add(1, "dmiss_issue",     1, 16'h0000, 0, 16'h7000, 16'h0000, 1, 0, 16'h0000, 0, 0, 0, 16'h7000, 16'h0000, 2'b10, 3'b010, 16'h0000, 3'b000, 16'h0000, 2'b10);
    add(1, "dmiss_wait",      1, 16'h0000, 0, 16'h7000, 16'h0000, 1, 0, 16'h0000, 0, 0, 0, 16'h7000, 16'h0000, 2'b10, 3'b010, 16'h0000, 3'b000, 16'h0000, 2'b10);
    add(0, "dmiss_rst",       0, 16'h0000, 0, 16'h7000, 16'h0000, 1, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 2'b00, 3'b000, 16'h0000, 3'b000, 16'h0000, 2'b00);
    add(1, "post_rst_i",      1, 16'h0100, 1, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 16'h0100, 16'h0000, 2'b10, 3'b000, 16'h0000, 3'b010, 16'h0000, 2'b00);
    add(1, "post_rst_idone",  1, 16'h0100, 1, 16'h0000, 16'h0000, 0, 0, 16'h1111, 1, 0, 0, 16'h0100, 16'h0000, 2'b10, 3'b100, 16'h1111, 3'b010, 16'h0000, 2'b00);
    add(1, "final_idle",      1, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 2'b00, 3'b000, 16'h0000, 3'b000, 16'h0000, 2'b00);

    foreach (vq[k]) begin
      @(posedge clk); #1;
      apply(vq[k]);
      @(negedge clk);
      if (vq[k].chk) check_vec(vq[k]);
    end

    // ---- grant timeout: memory never answers an I fetch ----
    @(posedge clk); #1;
    i_addr = 16'h0200; i_rd = 1'b1; m_data_out = 16'hDEAD; m_hit = 1'b1; m_done = 1'b0;
    @(negedge clk);
    checks++;
    if (m_rd !== 1'b1 || i_done !== 1'b0) begin
      errors++;
      $display("FAIL tmo_issue: got m_rd=%b i_done=%b, exp m_rd=1 i_done=0", m_rd, i_done);
    end
    n = 0; seen = 1'b0;
    for (int c = 1; c <= 100 && !seen; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (i_done === 1'b1) begin
        seen = 1'b1;
        n = c;
      end
    end
    checks++;
    if (n != 31) begin
      errors++;
      $display("FAIL tmo_cycle: i_done on grant cycle %0d, exp 31", n);
    end
    checks++;
    if (i_data_out !== 16'h0000 || i_hit !== 1'b0) begin
      errors++;
      $display("FAIL tmo_data: got data=%h hit=%b, exp data=0000 hit=0", i_data_out, i_hit);
    end
    @(posedge clk); #1;
    i_rd = 1'b0; m_hit = 1'b0; m_data_out = 16'h0000;
    @(negedge clk);
    checks++;
    if (err_timeout !== 1'b1 || m_rd !== 1'b0 || i_stall !== 1'b0 || i_done !== 1'b0) begin
      errors++;
      $display("FAIL tmo_after: got err_timeout=%b m_rd=%b i_stall=%b i_done=%b, exp 1 0 0 0",
               err_timeout, m_rd, i_stall, i_done);
    end

    // ---- repeated ties: both ports keep requesting, each access takes 2 cycles ----
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; i_addr = 16'h0100; d_addr = 16'h0200; i_rd = 1'b1; d_rd = 1'b1; m_done = 1'b0;
    for (int r = 0; r < 4; r++) begin
`ifdef ARB_RR_EN
      exp_d = (r % 2 == 0);
`else
      exp_d = 1'b1;
`endif
      @(posedge clk); #1; m_done = 1'b1;
      @(negedge clk);
      checks++;
      if (d_done !== exp_d || i_done !== !exp_d) begin
        errors++;
        $display("FAIL tie_order[%0d]: got d_done=%b i_done=%b, exp d_done=%b i_done=%b",
                 r, d_done, i_done, exp_d, !exp_d);
      end
      @(posedge clk); #1; m_done = 1'b0;
    end
    i_rd = 1'b0; d_rd = 1'b0;
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
